// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty feeder.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int unsigned DUTY_W_DEF   = 8;
  localparam int unsigned CLK_HZ       = 50_000_000;
  localparam int unsigned STEP_HZ      = 1_000;
  localparam int unsigned STEP_DIV_DEF = CLK_HZ / STEP_HZ;

endpackage

// File: rtl/sync_stab.sv
// Two-flop synchroniser followed by a stability filter; the output only follows the
// synchronised input once it has held the same value for STAB consecutive cycles.
module sync_stab
  import pwm_pkg::*;
#(
  parameter int unsigned W    = DUTY_W_DEF,
  parameter int unsigned STAB = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int unsigned CW = $clog2(STAB + 1);

  logic [W-1:0]  s1_q, s2_q, last_q, acc_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_d = number of consecutive cycles s2_q has shown its current value (saturating)
  always_comb begin
    cnt_d = cnt_q;
    if (s2_q != last_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q < CW'(STAB)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      last_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      last_q <= s2_q;
      cnt_q  <= cnt_d;
      if (cnt_d == CW'(STAB)) begin
        acc_q <= s2_q;
      end
    end
  end

  assign dout = acc_q;

endmodule

// File: rtl/pwm_duty_slew.sv
// Slews the committed PWM duty toward the debounced setpoint, committing only at period end.
// Define PWM_SLEW_BYPASS_EN to drop the rate limit and jump straight to the target.
module pwm_duty_slew
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_W    = DUTY_W_DEF,
  parameter int unsigned STEP_DIV  = STEP_DIV_DEF,
  parameter int unsigned STEP_SIZE = 1,
  parameter int unsigned STAB      = 4
) (
  input  logic              MAX10_CLK1_50,
  input  logic              rst,
  input  logic [DUTY_W-1:0] target,
  input  logic              hold,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_valid,
  output logic              busy
);

  logic              clk;
  state_t            state_q, state_d;
  logic [DUTY_W-1:0] tgt_acc, duty_q, next_q, step_val;
  logic              valid_q, busy_q, load_next, commit, tick;

  assign clk = MAX10_CLK1_50;

  sync_stab #(
    .W    (DUTY_W),
    .STAB (STAB)
  ) u_sync_stab (
    .clk  (clk),
    .rst  (rst),
    .din  (target),
    .dout (tgt_acc)
  );

`ifdef PWM_SLEW_BYPASS_EN
  assign tick     = 1'b1;
  assign step_val = tgt_acc;
`else
  localparam int unsigned PW = $clog2(STEP_DIV);
  localparam int unsigned EW = DUTY_W + 1;

  logic [PW-1:0] pre_q;
  logic          clr_pre;
  logic [EW-1:0] up_sum, dn_diff, ext_tgt;

  assign tick = (pre_q == PW'(STEP_DIV - 1));

  // One extra bit so overflow past full scale and underflow below zero clamp to target
  always_comb begin
    ext_tgt = {1'b0, tgt_acc};
    up_sum  = {1'b0, duty_q} + EW'(STEP_SIZE);
    dn_diff = {1'b0, duty_q} - EW'(STEP_SIZE);
    if (tgt_acc > duty_q) begin
      step_val = (up_sum > ext_tgt) ? tgt_acc : up_sum[DUTY_W-1:0];
    end else begin
      step_val = (dn_diff[DUTY_W] || (dn_diff < ext_tgt)) ? tgt_acc : dn_diff[DUTY_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else if (clr_pre || tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    load_next = 1'b0;
    commit    = 1'b0;
`ifndef PWM_SLEW_BYPASS_EN
    clr_pre   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (duty_q != tgt_acc) begin
`ifdef PWM_SLEW_BYPASS_EN
          if (!hold) begin
            state_d   = PEND;
            load_next = 1'b1;
          end else begin
            state_d = RAMP;
          end
`else
          state_d = RAMP;
          clr_pre = 1'b1;
`endif
        end
      end
      RAMP: begin
        if (tick && !hold) begin
          state_d   = PEND;
          load_next = 1'b1;
        end
      end
      PEND: begin
        if (period_end) begin
          commit  = 1'b1;
          state_d = (next_q == tgt_acc) ? IDLE : RAMP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
      next_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= commit;
      busy_q  <= (duty_q != tgt_acc);
      if (load_next) begin
        next_q <= step_val;
      end
      if (commit) begin
        duty_q <= next_q;
      end
    end
  end

  assign duty_out   = duty_q;
  assign duty_valid = valid_q;
  assign busy       = busy_q;

endmodule
